// File: rtl/vector_vector_alu_v2.sv
// Per-lane vector ALU: combines each input vector with a VRF operand, optionally caches
// the result back into the VRF, with per-chain firmware loaded over the config bus.
module vector_vector_alu_v2 #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter int VRF_DEPTH          = 8,
    parameter int SATURATE           = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tracing,
    input  logic                          valid_in,
    input  logic                          eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
    output logic                          valid_out,
    output logic                          eof_out
);
    localparam int CW = $clog2(MAX_CHAINS);
    localparam int AW = $clog2(VRF_DEPTH);
    localparam int DW = DATA_WIDTH;
    localparam int VW = N * DATA_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};

    // Firmware tables
    logic [7:0]    op_q         [MAX_CHAINS];
    logic [AW-1:0] rd_addr_q    [MAX_CHAINS];
    logic [7:0]    cond_q       [MAX_CHAINS];
    logic [7:0]    cache_q      [MAX_CHAINS];
    logic [AW-1:0] cache_addr_q [MAX_CHAINS];

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] chn_q, chn_d, cur_chn;
    logic [2:0]    fld_q, fld_d, cur_fld;
    logic          cfg_hit;

    // The matching byte that wakes the FSM from IDLE is itself slot 0.
    always_comb begin
        cfg_hit = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));
        cur_chn = (state_q == ST_IDLE) ? '0 : chn_q;
        cur_fld = (state_q == ST_IDLE) ? '0 : fld_q;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        chn_d   = chn_q;
        fld_d   = fld_q;
        if (tracing) begin
            state_d = ST_IDLE;
            chn_d   = '0;
            fld_d   = '0;
        end else if (cfg_hit) begin
            state_d = ST_LOAD;
            chn_d   = cur_chn;
            fld_d   = cur_fld + 3'd1;
            if (cur_fld == 3'd4) begin
                fld_d = '0;
                if (cur_chn == CW'(MAX_CHAINS - 1)) begin
                    chn_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    chn_d = cur_chn + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            chn_q   <= '0;
            fld_q   <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                op_q[c]         <= '0;
                rd_addr_q[c]    <= '0;
                cond_q[c]       <= '0;
                cache_q[c]      <= '0;
                cache_addr_q[c] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            chn_q   <= chn_d;
            fld_q   <= fld_d;
            if (cfg_hit) begin
                case (cur_fld)
                    3'd0:    op_q[cur_chn]         <= configData;
                    3'd1:    rd_addr_q[cur_chn]    <= configData[AW-1:0];
                    3'd2:    cond_q[cur_chn]       <= configData;
                    3'd3:    cache_q[cur_chn]      <= configData;
                    default: cache_addr_q[cur_chn] <= configData[AW-1:0];
                endcase
            end
        end
    end

    function automatic logic [DW-1:0] clamp(input logic [DW:0] x);
        if (SATURATE != 0 && x[DW] != x[DW-1]) return x[DW] ? SMIN : SMAX;
        return x[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] alu_lane(input logic [7:0] op,
                                               input logic [DW-1:0] m,
                                               input logic [DW-1:0] v);
        logic [DW:0]   sum;
        logic [DW:0]   dif;
        logic [DW-1:0] r;
        sum = {m[DW-1], m} + {v[DW-1], v};
        dif = {m[DW-1], m} - {v[DW-1], v};
        case (op)
            8'd1:    r = clamp(sum);
            8'd2:    r = m * v;
            8'd3:    r = clamp(dif);
            8'd4:    r = ($signed(m) > $signed(v)) ? m : v;
            8'd5:    r = ($signed(m) < $signed(v)) ? m : v;
            default: r = v;
        endcase
        return r;
    endfunction

    // Pipeline state
    logic [VW-1:0] vrf_q [VRF_DEPTH];
    logic [VW-1:0] s1_vec_q, s1_m_q, s1_m_d, alu_vec;
    logic          s1_valid_q, s1_eof_q;
    logic [CW-1:0] s1_chain_q;
    logic [7:0]    s1_op_q, s1_cond_q, s1_cache_q;
    logic [AW-1:0] s1_caddr_q, rd_addr;
    logic          cond_ok, wr_en;

    logic [VW-1:0] vec_out_q;
    logic [CW-1:0] chain_out_q;
    logic          valid_out_q, eof_out_q;

    always_comb begin
        alu_vec = '0;
        for (int l = 0; l < N; l++)
            alu_vec[l*DW +: DW] = alu_lane(s1_op_q, s1_m_q[l*DW +: DW], s1_vec_q[l*DW +: DW]);
    end

    always_comb begin
        case (s1_cond_q)
            8'd0:    cond_ok = 1'b1;
            8'd1:    cond_ok = s1_eof_q;
            8'd2:    cond_ok = !s1_eof_q;
            default: cond_ok = 1'b0;
        endcase
        wr_en   = tracing && s1_valid_q && (s1_cache_q != 8'd0) && cond_ok;
        rd_addr = rd_addr_q[chainId_in];
        // Forward the result being cached this cycle so back-to-back accumulation is exact.
        s1_m_d  = (wr_en && s1_caddr_q == rd_addr) ? alu_vec : vrf_q[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_chain_q  <= '0;
            s1_vec_q    <= '0;
            s1_m_q      <= '0;
            s1_op_q     <= '0;
            s1_cond_q   <= '0;
            s1_cache_q  <= '0;
            s1_caddr_q  <= '0;
            vec_out_q   <= '0;
            chain_out_q <= '0;
            valid_out_q <= 1'b0;
            eof_out_q   <= 1'b0;
            // NOTE: the VRF must read as zeros after reset, so it is cleared here
            // rather than left as an uninitialised memory.
            for (int i = 0; i < VRF_DEPTH; i++) vrf_q[i] <= '0;
        end else begin
            s1_valid_q  <= tracing && valid_in;
            s1_eof_q    <= eof_in;
            s1_chain_q  <= chainId_in;
            s1_vec_q    <= vector_in;
            s1_m_q      <= s1_m_d;
            s1_op_q     <= op_q[chainId_in];
            s1_cond_q   <= cond_q[chainId_in];
            s1_cache_q  <= cache_q[chainId_in];
            s1_caddr_q  <= cache_addr_q[chainId_in];
            valid_out_q <= tracing && s1_valid_q;
            eof_out_q   <= tracing && s1_valid_q && s1_eof_q;
            if (tracing) begin
                vec_out_q   <= alu_vec;
                chain_out_q <= s1_chain_q;
            end
            if (wr_en) vrf_q[s1_caddr_q] <= alu_vec;
        end
    end

    assign vector_out  = vec_out_q;
    assign chainId_out = chain_out_q;
    assign valid_out   = valid_out_q;
    assign eof_out     = eof_out_q;
endmodule

// File: tb/tb_vector_vector_alu_v2.sv
// Directed bench: one 32-bit wrapping instance plus two 8-bit instances (saturating / wrapping)
// sharing control and config inputs.
module tb_vector_vector_alu_v2;
    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         tracing = 1'b0;
    logic         valid_in = 1'b0;
    logic         eof_in = 1'b0;
    logic [1:0]   chainId_in = '0;
    logic [7:0]   configId = 8'hFF;
    logic [7:0]   configData = '0;
    logic [255:0] vector_in = '0;
    logic [63:0]  vector_in8 = '0;

    logic [255:0] vector_out;
    logic [1:0]   chainId_out;
    logic         valid_out, eof_out;
    logic [63:0]  vout_s8, vout_w8;
    logic [1:0]   cid_s8, cid_w8;
    logic         vld_s8, vld_w8, eof_s8, eof_w8;

    int errors = 0;
    int checks = 0;
    logic [7:0] cfg [20];

    always #5 clk = ~clk;

    vector_vector_alu_v2 dut (
        .clk(clk), .reset_n(reset_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData),
        .vector_in(vector_in), .vector_out(vector_out), .chainId_out(chainId_out),
        .valid_out(valid_out), .eof_out(eof_out)
    );

    vector_vector_alu_v2 #(.DATA_WIDTH(8), .SATURATE(1)) dut_s8 (
        .clk(clk), .reset_n(reset_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData),
        .vector_in(vector_in8), .vector_out(vout_s8), .chainId_out(cid_s8),
        .valid_out(vld_s8), .eof_out(eof_s8)
    );

    vector_vector_alu_v2 #(.DATA_WIDTH(8), .SATURATE(0)) dut_w8 (
        .clk(clk), .reset_n(reset_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData),
        .vector_in(vector_in8), .vector_out(vout_w8), .chainId_out(cid_w8),
        .valid_out(vld_w8), .eof_out(eof_w8)
    );

    function automatic logic [255:0] splat32(input int val);
        logic [31:0] w;
        w = val;
        return {8{w}};
    endfunction

    function automatic logic [63:0] splat8(input int val);
        logic [31:0] w;
        w = val;
        return {8{w[7:0]}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic e, input int val);
        chainId_in = 2'(ch);
        valid_in   = v;
        eof_in     = e;
        vector_in  = splat32(val);
        vector_in8 = splat8(val);
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 20; i++) cfg[i] = 8'h00;
    endtask

    task automatic set_chain(input int c, input int op, input int ra, input int cd,
                             input int ca, input int cadr);
        cfg[c*5+0] = 8'(op);
        cfg[c*5+1] = 8'(ra);
        cfg[c*5+2] = 8'(cd);
        cfg[c*5+3] = 8'(ca);
        cfg[c*5+4] = 8'(cadr);
    endtask

    // Loads the 20-byte table; before byte index p1/p2 two non-matching cycles are inserted.
    task automatic load_cfg(input int p1, input int p2);
        drive(0, 1'b0, 1'b0, 0);
        tracing = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == p1 || i == p2) begin
                configId = 8'h55; configData = 8'hAA;
                tick(); tick();
            end
            configId = 8'h00; configData = cfg[i];
            tick();
        end
        configId = 8'hFF;
        tick();
        tracing = 1'b1;
    endtask

    task automatic test_reset();
        logic [255:0] exp;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({vector_out, valid_out, eof_out, chainId_out} !== '0) begin
            errors++; $display("FAIL reset_outputs: vector_out=%h valid=%b eof=%b chain=%0d, expected all 0",
                               vector_out, valid_out, eof_out, chainId_out);
        end
        tick(); tick();
        reset_n = 1'b1;
        tracing = 1'b1;
        tick();
        for (int l = 0; l < 8; l++) exp[l*32 +: 32] = 32'(l + 1);
        chainId_in = 2'd0; valid_in = 1'b1; eof_in = 1'b0; vector_in = exp;
        tick();
        drive(0, 1'b0, 1'b0, 0);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL pass_latency_t1: valid_out=%b expected 0", valid_out);
        end
        tick();
        checks++;
        if ({valid_out, chainId_out, vector_out} !== {1'b1, 2'd0, exp}) begin
            errors++; $display("FAIL pass_default_op: valid=%b chain=%0d vec=%h expected 1 0 %h",
                               valid_out, chainId_out, vector_out, exp);
        end
    endtask

    task automatic test_accumulate();
        clear_cfg();
        set_chain(1, 1, 3, 0, 1, 3);
        load_cfg(-1, -1);
        drive(1, 1'b1, 1'b0, 5);
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) drive(1, 1'b1, 1'b0, 5); else drive(1, 1'b0, 1'b0, 0);
            tick();
            checks++;
            if ({valid_out, chainId_out, vector_out} !== {1'b1, 2'd1, splat32(5 * k)}) begin
                errors++; $display("FAIL accum_%0d: valid=%b chain=%0d vec=%h expected 1 1 %h",
                                   k, valid_out, chainId_out, vector_out, splat32(5 * k));
            end
        end
        tick();
        drive(1, 1'b1, 1'b0, 0);
        tick();
        drive(1, 1'b0, 1'b0, 0);
        tick();
        checks++;
        if (vector_out !== splat32(20)) begin
            errors++; $display("FAIL accum_vrf3: vec=%h expected %h", vector_out, splat32(20));
        end
    endtask

    task automatic test_saturation();
        clear_cfg();
        set_chain(0, 0, 0, 0, 1, 5);
        set_chain(1, 0, 0, 0, 1, 6);
        set_chain(2, 1, 5, 0, 0, 0);
        set_chain(3, 3, 6, 0, 0, 0);
        load_cfg(-1, -1);
        drive(0, 1'b1, 1'b0, 100);  tick();
        drive(1, 1'b1, 1'b0, -100); tick();
        drive(2, 1'b1, 1'b0, 100);  tick();
        checks++;
        if (vout_s8 !== splat8(-100)) begin
            errors++; $display("FAIL sat_pass_neg: vec=%h expected %h", vout_s8, splat8(-100));
        end
        drive(3, 1'b1, 1'b0, 100);  tick();
        checks++;
        if (vout_s8 !== splat8(127)) begin
            errors++; $display("FAIL sat_add_clamp: vec=%h expected %h", vout_s8, splat8(127));
        end
        checks++;
        if (vout_w8 !== splat8(-56)) begin
            errors++; $display("FAIL wrap_add: vec=%h expected %h", vout_w8, splat8(-56));
        end
        checks++;
        if (vector_out !== splat32(200)) begin
            errors++; $display("FAIL add32: vec=%h expected %h", vector_out, splat32(200));
        end
        drive(0, 1'b0, 1'b0, 0); tick();
        checks++;
        if (vout_s8 !== splat8(-128)) begin
            errors++; $display("FAIL sat_sub_clamp: vec=%h expected %h", vout_s8, splat8(-128));
        end
        checks++;
        if (vout_w8 !== splat8(56)) begin
            errors++; $display("FAIL wrap_sub: vec=%h expected %h", vout_w8, splat8(56));
        end
        checks++;
        if (vector_out !== splat32(-200)) begin
            errors++; $display("FAIL sub32: vec=%h expected %h", vector_out, splat32(-200));
        end
    endtask

    task automatic test_ops();
        clear_cfg();
        set_chain(0, 2, 5, 0, 0, 0);
        set_chain(1, 4, 6, 0, 0, 0);
        set_chain(2, 5, 6, 0, 0, 0);
        set_chain(3, 7, 5, 0, 0, 0);
        load_cfg(-1, -1);
        drive(0, 1'b1, 1'b0, 3); tick();
        drive(1, 1'b1, 1'b0, 3); tick();
        checks++;
        if (vector_out !== splat32(300)) begin
            errors++; $display("FAIL mul32: vec=%h expected %h", vector_out, splat32(300));
        end
        checks++;
        if (vout_s8 !== splat8(44)) begin
            errors++; $display("FAIL mul8_wraps: vec=%h expected %h", vout_s8, splat8(44));
        end
        drive(2, 1'b1, 1'b0, 3); tick();
        checks++;
        if (vector_out !== splat32(3)) begin
            errors++; $display("FAIL max_signed: vec=%h expected %h", vector_out, splat32(3));
        end
        drive(3, 1'b1, 1'b0, 3); tick();
        checks++;
        if (vector_out !== splat32(-100)) begin
            errors++; $display("FAIL min_signed: vec=%h expected %h", vector_out, splat32(-100));
        end
        drive(0, 1'b0, 1'b0, 0); tick();
        checks++;
        if (vector_out !== splat32(3)) begin
            errors++; $display("FAIL op_other: vec=%h expected %h", vector_out, splat32(3));
        end
    endtask

    task automatic test_cond_cache();
        clear_cfg();
        set_chain(0, 1, 2, 1, 1, 2);
        set_chain(1, 1, 2, 0, 0, 0);
        set_chain(2, 1, 2, 2, 1, 2);
        load_cfg(-1, -1);
        drive(0, 1'b1, 1'b0, 7);  tick();
        drive(0, 1'b1, 1'b0, 11); tick();
        checks++;
        if ({vector_out, eof_out} !== {splat32(7), 1'b0}) begin
            errors++; $display("FAIL cond_v1: vec=%h eof=%b expected %h 0", vector_out, eof_out, splat32(7));
        end
        drive(0, 1'b1, 1'b1, 13); tick();
        checks++;
        if ({vector_out, eof_out} !== {splat32(11), 1'b0}) begin
            errors++; $display("FAIL cond_v2: vec=%h eof=%b expected %h 0", vector_out, eof_out, splat32(11));
        end
        drive(0, 1'b0, 1'b0, 0); tick();
        checks++;
        if ({vector_out, eof_out} !== {splat32(13), 1'b1}) begin
            errors++; $display("FAIL cond_v3: vec=%h eof=%b expected %h 1", vector_out, eof_out, splat32(13));
        end
        drive(1, 1'b1, 1'b0, 1); tick();
        drive(2, 1'b1, 1'b1, 1); tick();
        checks++;
        if (vector_out !== splat32(14)) begin
            errors++; $display("FAIL cond_readback: vec=%h expected %h", vector_out, splat32(14));
        end
        drive(1, 1'b1, 1'b0, 0); tick();
        checks++;
        if (vector_out !== splat32(14)) begin
            errors++; $display("FAIL cond2_eof: vec=%h expected %h", vector_out, splat32(14));
        end
        drive(1, 1'b0, 1'b0, 0); tick();
        checks++;
        if (vector_out !== splat32(13)) begin
            errors++; $display("FAIL cond2_nowrite: vec=%h expected %h", vector_out, splat32(13));
        end
    endtask

    task automatic test_tracing_drop();
        clear_cfg();
        set_chain(0, 1, 4, 0, 1, 4);
        load_cfg(-1, -1);
        drive(0, 1'b1, 1'b0, 2); tick();
        drive(0, 1'b1, 1'b0, 3); tick();
        checks++;
        if ({valid_out, vector_out} !== {1'b1, splat32(2)}) begin
            errors++; $display("FAIL drop_before: valid=%b vec=%h expected 1 %h", valid_out, vector_out, splat32(2));
        end
        drive(0, 1'b1, 1'b0, 4);
        tracing = 1'b0;
        tick();
        checks++;
        if ({valid_out, vector_out} !== {1'b0, splat32(2)}) begin
            errors++; $display("FAIL drop_next_edge: valid=%b vec=%h expected 0 %h", valid_out, vector_out, splat32(2));
        end
        drive(0, 1'b0, 1'b0, 0); tick(); tick();
        checks++;
        if ({valid_out, vector_out} !== {1'b0, splat32(2)}) begin
            errors++; $display("FAIL drop_hold: valid=%b vec=%h expected 0 %h", valid_out, vector_out, splat32(2));
        end
        tracing = 1'b1;
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL drop_no_stale: valid_out=%b expected 0", valid_out);
        end
        drive(0, 1'b1, 1'b0, 5); tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL resume_t1: valid_out=%b expected 0", valid_out);
        end
        drive(0, 1'b0, 1'b0, 0); tick();
        checks++;
        if ({valid_out, vector_out} !== {1'b1, splat32(7)}) begin
            errors++; $display("FAIL resume_t2: valid=%b vec=%h expected 1 %h", valid_out, vector_out, splat32(7));
        end
    endtask

    task automatic test_pause_and_reset();
        int exp_out [5];
        exp_out = '{50, 54, 46, 4, 51};
        clear_cfg();
        set_chain(0, 1, 7, 3, 1, 0);
        set_chain(1, 3, 7, 0, 0, 0);
        set_chain(2, 5, 7, 0, 0, 1);
        set_chain(3, 0, 0, 0, 1, 7);
        load_cfg(3, 11);
        drive(3, 1'b1, 1'b0, 50); tick();
        drive(0, 1'b1, 1'b0, 4);  tick();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: drive(1, 1'b1, 1'b0, 4);
                1: drive(2, 1'b1, 1'b0, 4);
                2: drive(0, 1'b1, 1'b0, 1);
                default: drive(0, 1'b0, 1'b0, 0);
            endcase
            checks++;
            if (vector_out !== splat32(exp_out[k])) begin
                errors++; $display("FAIL pause_table_%0d: vec=%h expected %h", k, vector_out, splat32(exp_out[k]));
            end
            tick();
        end
        drive(1, 1'b1, 1'b1, 4); tick();
        tick();
        checks++;
        if ({valid_out, eof_out, chainId_out, vector_out} !== {1'b1, 1'b1, 2'd1, splat32(46)}) begin
            errors++; $display("FAIL pre_reset: valid=%b eof=%b chain=%0d vec=%h expected 1 1 1 %h",
                               valid_out, eof_out, chainId_out, vector_out, splat32(46));
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({vector_out, valid_out, eof_out, chainId_out} !== '0) begin
            errors++; $display("FAIL midstream_reset: vec=%h valid=%b eof=%b chain=%0d expected all 0",
                               vector_out, valid_out, eof_out, chainId_out);
        end
        tick();
        reset_n = 1'b1;
        drive(1, 1'b0, 1'b0, 0);
        tick(); tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: valid_out=%b expected 0", valid_out);
        end
        drive(1, 1'b1, 1'b0, 9); tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL post_reset_t1: valid_out=%b expected 0", valid_out);
        end
        drive(1, 1'b0, 1'b0, 0); tick();
        checks++;
        if ({valid_out, chainId_out, vector_out} !== {1'b1, 2'd1, splat32(9)}) begin
            errors++; $display("FAIL post_reset_fw_zero: valid=%b chain=%0d vec=%h expected 1 1 %h",
                               valid_out, chainId_out, vector_out, splat32(9));
        end
        clear_cfg();
        set_chain(0, 1, 7, 0, 0, 0);
        load_cfg(-1, -1);
        drive(0, 1'b1, 1'b0, 0); tick();
        drive(0, 1'b0, 1'b0, 0); tick();
        checks++;
        if ({valid_out, vector_out} !== {1'b1, splat32(0)}) begin
            errors++; $display("FAIL post_reset_vrf_zero: valid=%b vec=%h expected 1 %h",
                               valid_out, vector_out, splat32(0));
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_saturation();
        test_ops();
        test_cond_cache();
        test_tracing_drop();
        test_pause_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
